// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-way word mux with manual select, auto-scan and hold/freeze.
// Latency: 1 clock from select/data to o; no backpressure, hold freezes o, cur_s and dwell count.
module mux_scan_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          o,
  output logic [SEL_W-1:0]          cur_s,
  output logic                      o_valid
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {ST_MAN, ST_SCAN, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  o_q, o_d;
  logic [SEL_W-1:0]  cur_s_q, cur_s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              o_valid_q, o_valid_d;
  logic              scan_susp_q, scan_susp_d;
  logic [CNT_W-1:0]  cnt_base;
  logic [WIDTH-1:0]  sel_dat;

  // The action taken on an edge follows the state being entered, so mode/hold
  // changes take effect on the very edge they are first sampled.
  always_comb begin
    state_d     = state_q;
    cur_s_d     = cur_s_q;
    cnt_d       = cnt_q;
    o_d         = o_q;
    scan_susp_d = scan_susp_q;
    sel_dat     = '0;

    if (hold) begin
      state_d = ST_HOLD;
    end else if (mode) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_MAN;
    end

    // Leaving a hold that interrupted manual mode restarts the dwell period.
    cnt_base = (state_q == ST_HOLD && !scan_susp_q) ? '0 : cnt_q;

    case (state_d)
      ST_MAN: begin
        cur_s_d = s;
        cnt_d   = '0;
      end
      ST_SCAN: begin
        if (cnt_base == CNT_LAST) begin
          cnt_d   = '0;
          cur_s_d = (cur_s_q >= SEL_LAST) ? '0 : cur_s_q + 1'b1;
        end else begin
          cnt_d = cnt_base + 1'b1;
        end
      end
      ST_HOLD: begin
        if (state_q != ST_HOLD) begin
          scan_susp_d = (state_q == ST_SCAN);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // Out-of-range selects match no channel and read as zero.
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_s_d == SEL_W'(k)) begin
        sel_dat = I[k*WIDTH +: WIDTH];
      end
    end

    if (state_d != ST_HOLD) begin
      o_d = sel_dat;
    end

    o_valid_d = (cur_s_d != cur_s_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_MAN;
      o_q         <= '0;
      cur_s_q     <= '0;
      cnt_q       <= '0;
      o_valid_q   <= 1'b0;
      scan_susp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      cur_s_q     <= cur_s_d;
      cnt_q       <= cnt_d;
      o_valid_q   <= o_valid_d;
      scan_susp_q <= scan_susp_d;
    end
  end

  assign o       = o_q;
  assign cur_s   = cur_s_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: an 8-channel DWELL=4 unit and a 5-channel DWELL=3 unit,
// directed steps followed by random traffic, all checked against a behavioural model.
module tb_mux_scan_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  din [2][8];
  logic [2:0]   sv  [2];
  logic         md  [2];
  logic         hd  [2];
  logic [255:0] i_bus0;
  logic [159:0] i_bus1;

  logic [31:0] o0, o1;
  logic [2:0]  c0, c1;
  logic        v0, v1;

  always_comb begin
    i_bus0 = '0;
    i_bus1 = '0;
    for (int k = 0; k < 8; k++) i_bus0[k*32 +: 32] = din[0][k];
    for (int k = 0; k < 5; k++) i_bus1[k*32 +: 32] = din[1][k];
  end

  mux_scan_reg #(.WIDTH(32), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .I(i_bus0), .s(sv[0]), .mode(md[0]), .hold(hd[0]),
    .o(o0), .cur_s(c0), .o_valid(v0)
  );

  mux_scan_reg #(.WIDTH(32), .CHANNELS(5), .SEL_W(3), .DWELL(3)) dut5 (
    .clk(clk), .rst(rst), .I(i_bus1), .s(sv[1]), .mode(md[1]), .hold(hd[1]),
    .o(o1), .cur_s(c1), .o_valid(v1)
  );

  logic [31:0] ref_word [8];
  int          m_cur [2];
  int          m_cnt [2];
  logic [31:0] m_o   [2];
  logic        m_vld [2];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: selected channel, dwell position and output word per unit,
  // advanced once per clock edge from the inputs seen before that edge.
  task automatic mdl(input int u);
    int n, d, prev;
    n = (u == 0) ? 8 : 5;
    d = (u == 0) ? 4 : 3;
    if (rst) begin
      m_cur[u] = 0; m_cnt[u] = 0; m_o[u] = '0; m_vld[u] = 1'b0;
      return;
    end
    prev = m_cur[u];
    if (hd[u]) begin
      m_vld[u] = 1'b0;
    end else begin
      if (!md[u]) begin
        m_cur[u] = int'(sv[u]);
        m_cnt[u] = 0;
      end else if (m_cnt[u] == d - 1) begin
        m_cnt[u] = 0;
        m_cur[u] = (m_cur[u] + 1 >= n) ? 0 : m_cur[u] + 1;
      end else begin
        m_cnt[u] = m_cnt[u] + 1;
      end
      m_o[u]   = (m_cur[u] < n) ? din[u][m_cur[u]] : 32'h0;
      m_vld[u] = (m_cur[u] != prev);
    end
  endtask

  task automatic step();
    mdl(0);
    mdl(1);
    @(posedge clk);
    #1;
    chk("o_u8",    64'(o0), 64'(m_o[0]));
    chk("cur_u8",  64'(c0), 64'(m_cur[0]));
    chk("vld_u8",  64'(v0), 64'(m_vld[0]));
    chk("o_u5",    64'(o1), 64'(m_o[1]));
    chk("cur_u5",  64'(c1), 64'(m_cur[1]));
    chk("vld_u5",  64'(v1), 64'(m_vld[1]));
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_o"},   64'({o0, o1}), 64'h0);
    chk({tag, "_cur"}, 64'({c0, c1}), 64'h0);
    chk({tag, "_vld"}, 64'({v0, v1}), 64'h0);
  endtask

  initial begin
    int g, pulses, exp_c, n;
    ref_word = '{32'hAA550000, 32'h55AA1111, 32'hAA552222, 32'h55AA3333,
                 32'hAA554444, 32'h55AA5555, 32'hAA556666, 32'h55AA7777};
    for (int k = 0; k < 8; k++) begin
      din[0][k] = ref_word[k];
      din[1][k] = 32'hC0DE0000 | 32'(k);
    end
    for (int u = 0; u < 2; u++) begin
      sv[u] = '0; md[u] = 1'b0; hd[u] = 1'b0;
      m_cur[u] = 0; m_cnt[u] = 0; m_o[u] = '0; m_vld[u] = 1'b0;
    end

    // Reset state, before and across an edge.
    #2;
    rst_chk("rst_init");
    @(posedge clk);
    #1;
    rst_chk("rst_edge");
    rst = 1'b0;

    // Manual sweep on the 8-channel unit; 5-channel unit goes s=6 then SCAN.
    sv[1] = 3'd6;
    g = 0;
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      sv[0] = 3'(s);
      for (int r = 0; r < 5; r++) begin
        if (g == 5) md[1] = 1'b1;
        step();
        g++;
        if (r == 0) chk("sweep_o", 64'(o0), 64'(ref_word[s]));
        chk("sweep_pulse", 64'(v0), 64'(r == 0 && s != 0));
        if (v0) pulses++;
        exp_c = (g <= 7) ? 6 : ((g - 8) / 3) % 5;
        chk("n5_cur", 64'(c1), 64'(exp_c));
        chk("n5_o", 64'(o1), (g <= 7) ? 64'h0 : 64'(din[1][exp_c]));
      end
    end
    chk("sweep_pulses", 64'(pulses), 64'd7);

    // Reset between edges, then auto-scan from reset.
    #3;
    rst = 1'b1;
    #1;
    rst_chk("rst_pre_scan");
    md[0] = 1'b1;
    step();
    rst_chk("rst_held");
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_c = (k / 4) % 8;
      chk("scan_cur", 64'(c0), 64'(exp_c));
      chk("scan_o", 64'(o0), 64'(ref_word[exp_c]));
      if (v0) pulses++;
    end
    chk("scan_pulses", 64'(pulses), 64'd9);

    // Hold on channel 3 at dwell position 2.
    n = 0;
    while (!(m_cur[0] == 3 && m_cnt[0] == 2) && n < 100) begin
      step();
      n++;
    end
    chk("hold_reach", 64'(n < 100), 64'd1);
    chk("hold_pre_cur", 64'(c0), 64'd3);
    hd[0] = 1'b1;
    for (int h = 0; h < 10; h++) begin
      step();
      if (h == 0) din[0][3] = 32'h12345678;
      chk("hold_o", 64'(o0), 64'h55AA3333);
      chk("hold_cur", 64'(c0), 64'd3);
      chk("hold_vld", 64'(v0), 64'd0);
    end
    hd[0] = 1'b0;
    step();
    chk("rel_o", 64'(o0), 64'h12345678);
    chk("rel_cur", 64'(c0), 64'd3);
    step();
    chk("rel_adv_cur", 64'(c0), 64'd4);
    chk("rel_adv_vld", 64'(v0), 64'd1);
    din[0][3] = ref_word[3];

    // Asynchronous reset while scanning channel 5.
    n = 0;
    while (m_cur[0] != 5 && n < 100) begin
      step();
      n++;
    end
    chk("rst5_reach", 64'(c0), 64'd5);
    #3;
    rst = 1'b1;
    #1;
    rst_chk("rst_async");
    step();
    rst_chk("rst_async_held");
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("restart_cur", 64'(c0), (k == 4) ? 64'd1 : 64'd0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int u = 0; u < 2; u++) begin
        if ($urandom_range(0, 15) == 0) md[u] = ~md[u];
        if ($urandom_range(0, 9) == 0) hd[u] = ~hd[u];
        sv[u] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) din[u][$urandom_range(0, 7)] = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
